// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_pkg
// Description : Shared definitions for the 1-to-4 demultiplexer stream block:
//               route select codes and output slot state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

    // Route select codes carried on S
    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;
    localparam logic [1:0] SEL_D = 2'd3;

    // Number of output slots
    localparam int NUM_OUT = 4;

    // One-entry holding slot state
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_t;

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_out_slot.sv
`default_nettype none
// ============================================================================
// Module      : demux_out_slot
// Description : One-entry output holding register with EMPTY/FULL FSM and a
//               saturating count of loaded words.
//   clk        in   1      clock
//   rst_n      in   1      asynchronous active-low reset
//   load       in   1      write din into the slot this cycle
//   din        in   N      word to load
//   ready      in   1      consumer ready
//   dout       out  N      held word (keeps last value when EMPTY)
//   valid      out  1      slot FULL
//   can_accept out  1      slot can take a load this cycle
//   cnt        out  CNT_W  saturating count of loads
// Revision    : 1.0 - initial release
// ============================================================================
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [N-1:0]     din,
    input  logic             ready,
    output logic [N-1:0]     dout,
    output logic             valid,
    output logic             can_accept,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    slot_state_t      r_state;
    logic [N-1:0]     r_data;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            // A load wins over a drain: in FULL with ready=1 this is the
            // pass-through case, the new word replaces the one leaving.
            if (load) begin
                r_data <= din;
                if (r_cnt != C_CNT_MAX) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
            case (r_state)
                ST_EMPTY: begin
                    if (load) begin
                        r_state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (ready && !load) begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    assign dout       = r_data;
    assign valid      = (r_state == ST_FULL);
    assign can_accept = (r_state == ST_EMPTY) || ready;
    assign cnt        = r_cnt;

endmodule : demux_out_slot
`default_nettype wire

// File: rtl/nbit_1x4_demux_stream.sv
`default_nettype none
// ============================================================================
// Module      : nbit_1x4_demux_stream
// Description : Registered 1-to-4 demultiplexer. One word per cycle on a
//               valid/ready input is steered by S to output A/B/C/D, each of
//               which owns a one-entry slot with its own valid/ready pair and
//               a saturating beat counter.
//   clk, rst_n          clock, asynchronous active-low reset
//   Y, S, in_valid      input word, route select, input valid
//   in_ready            input can be taken (depends on S and selected slot)
//   A..D, vA..vD        per-output data and valid
//   rA..rD              per-output consumer ready
//   cntA..cntD          per-output accepted-word count (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module nbit_1x4_demux_stream
    import demux_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     Y,
    input  logic [1:0]       S,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N-1:0]     A,
    output logic [N-1:0]     B,
    output logic [N-1:0]     C,
    output logic [N-1:0]     D,
    output logic             vA,
    output logic             vB,
    output logic             vC,
    output logic             vD,
    input  logic             rA,
    input  logic             rB,
    input  logic             rC,
    input  logic             rD,
    output logic [CNT_W-1:0] cntA,
    output logic [CNT_W-1:0] cntB,
    output logic [CNT_W-1:0] cntC,
    output logic [CNT_W-1:0] cntD
);

    logic [NUM_OUT-1:0] w_ready;
    logic [NUM_OUT-1:0] w_accept;
    logic [NUM_OUT-1:0] w_load;
    logic [NUM_OUT-1:0] w_valid;
    logic [N-1:0]       w_data [NUM_OUT];
    logic [CNT_W-1:0]   w_cnt  [NUM_OUT];
    logic               w_xfer;

    assign w_ready = {rD, rC, rB, rA};

    // Only the selected slot gates the input; in_valid never feeds back.
    assign in_ready = w_accept[S];
    assign w_xfer   = in_valid && in_ready;

    generate
        for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_slot
            assign w_load[gi] = w_xfer && (S == 2'(gi));

            demux_out_slot #(
                .N     (N),
                .CNT_W (CNT_W)
            ) u_slot (
                .clk        (clk),
                .rst_n      (rst_n),
                .load       (w_load[gi]),
                .din        (Y),
                .ready      (w_ready[gi]),
                .dout       (w_data[gi]),
                .valid      (w_valid[gi]),
                .can_accept (w_accept[gi]),
                .cnt        (w_cnt[gi])
            );
        end
    endgenerate

    assign A    = w_data[SEL_A];
    assign B    = w_data[SEL_B];
    assign C    = w_data[SEL_C];
    assign D    = w_data[SEL_D];
    assign vA   = w_valid[SEL_A];
    assign vB   = w_valid[SEL_B];
    assign vC   = w_valid[SEL_C];
    assign vD   = w_valid[SEL_D];
    assign cntA = w_cnt[SEL_A];
    assign cntB = w_cnt[SEL_B];
    assign cntC = w_cnt[SEL_C];
    assign cntD = w_cnt[SEL_D];

endmodule : nbit_1x4_demux_stream
`default_nettype wire

// File: tb/tb_nbit_1x4_demux_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_nbit_1x4_demux_stream
// Description : Self-checking bench for nbit_1x4_demux_stream. A queue per
//               output holds words the bench expects to appear there; words
//               are pushed when an input transfer is seen and popped when the
//               output hands a word to its consumer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nbit_1x4_demux_stream;

    localparam int N     = 8;
    localparam int CNT_W = 2;
    localparam int C_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     Y;
    logic [1:0]       S;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     A, B, C, D;
    logic             vA, vB, vC, vD;
    logic [3:0]       r;
    logic [CNT_W-1:0] cntA, cntB, cntC, cntD;

    logic [N-1:0]     dout [4];
    logic [CNT_W-1:0] cnt  [4];
    logic [3:0]       v;

    assign dout[0] = A;    assign dout[1] = B;    assign dout[2] = C;    assign dout[3] = D;
    assign cnt[0]  = cntA; assign cnt[1]  = cntB; assign cnt[2]  = cntC; assign cnt[3]  = cntD;
    assign v       = {vD, vC, vB, vA};

    always #5 clk = ~clk;

    nbit_1x4_demux_stream #(
        .N     (N),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Y        (Y),
        .S        (S),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .C        (C),
        .D        (D),
        .vA       (vA),
        .vB       (vB),
        .vC       (vC),
        .vD       (vD),
        .rA       (r[0]),
        .rB       (r[1]),
        .rC       (r[2]),
        .rD       (r[3]),
        .cntA     (cntA),
        .cntB     (cntB),
        .cntC     (cntC),
        .cntD     (cntD)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [N-1:0] q [4][$];
    int           mcnt [4];
    bit           mon_en = 1'b0;

    task automatic clear_model();
        for (int x = 0; x < 4; x++) begin
            q[x].delete();
            mcnt[x] = 0;
        end
    endtask

    always @(negedge clk) begin : mon
        logic exp_rdy;
        if (mon_en && rst_n) begin
            exp_rdy = (q[S].size() == 0) || r[S];
            chk("sb_in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            for (int x = 0; x < 4; x++) begin
                chk($sformatf("sb_valid%0d", x), {31'd0, v[x]}, {31'd0, q[x].size() != 0});
                if (q[x].size() != 0)
                    chk($sformatf("sb_data%0d", x), 32'(dout[x]), 32'(q[x][0]));
                chk($sformatf("sb_cnt%0d", x), 32'(cnt[x]), mcnt[x]);
            end
            for (int x = 0; x < 4; x++)
                if (r[x] && q[x].size() != 0) void'(q[x].pop_front());
            if (in_valid && exp_rdy) begin
                q[S].push_back(Y);
                if (mcnt[S] < C_MAX) mcnt[S]++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [1:0] s, input logic [N-1:0] y, input logic vld);
        @(posedge clk);
        #1;
        S        = s;
        Y        = y;
        in_valid = vld;
    endtask

    task automatic reset_state_checks(input string tag);
        for (int x = 0; x < 4; x++) begin
            chk($sformatf("%s_v%0d", tag, x),   {31'd0, v[x]}, 32'd0);
            chk($sformatf("%s_cnt%0d", tag, x), 32'(cnt[x]), 32'd0);
            chk($sformatf("%s_d%0d", tag, x),   32'(dout[x]), 32'd0);
        end
    endtask

    task automatic release_reset(input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        clear_model();
        @(negedge clk);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        mon_en = 1'b1;
    endtask

    typedef struct {
        logic [1:0]   s;
        logic [N-1:0] y;
        logic         vld;
        logic [3:0]   rdy;
        logic         exp_ready;
    } vec_t;

    vec_t tbl [6];

    initial begin
        // Scenario 1: reset with in_valid held high
        rst_n    = 1'b0;
        in_valid = 1'b1;
        S        = 2'd0;
        Y        = 8'hFF;
        r        = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_state_checks("rst1");
        release_reset("rst1");

        // Scenario 2: routing, one word per output
        tbl[0] = '{2'd0, 8'h55, 1'b1, 4'hF, 1'b1};
        tbl[1] = '{2'd1, 8'hAA, 1'b1, 4'hF, 1'b1};
        tbl[2] = '{2'd2, 8'hF0, 1'b1, 4'hF, 1'b1};
        tbl[3] = '{2'd3, 8'h0F, 1'b1, 4'hF, 1'b1};
        tbl[4] = '{2'd0, 8'h00, 1'b0, 4'hF, 1'b1};
        tbl[5] = '{2'd1, 8'h00, 1'b0, 4'hF, 1'b1};
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].s, tbl[i].y, tbl[i].vld);
            r = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("tbl%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].exp_ready});
        end
        drive(2'd0, 8'h00, 1'b0);
        @(negedge clk);
        chk("route_A_hold", 32'(A), 32'h55);
        chk("route_B_hold", 32'(B), 32'hAA);
        chk("route_C_hold", 32'(C), 32'hF0);
        chk("route_D_hold", 32'(D), 32'h0F);
        for (int x = 0; x < 4; x++)
            chk($sformatf("route_cnt%0d", x), 32'(cnt[x]), 32'd1);

        // Scenario 3: stall isolation on B
        drive(2'd1, 8'hAA, 1'b1);
        r = 4'b1101;
        drive(2'd1, 8'hBB, 1'b1);
        @(negedge clk);
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        chk("stall_vB", {31'd0, vB}, 32'd1);
        chk("stall_B", 32'(B), 32'hAA);
        drive(2'd2, 8'hF0, 1'b1);
        @(negedge clk);
        chk("other_in_ready", {31'd0, in_ready}, 32'd1);
        drive(2'd0, 8'h00, 1'b0);
        @(negedge clk);
        chk("other_vC", {31'd0, vC}, 32'd1);
        chk("other_C", 32'(C), 32'hF0);
        chk("stall_B_still", 32'(B), 32'hAA);
        r = 4'hF;
        drive(2'd0, 8'h00, 1'b0);
        drive(2'd0, 8'h00, 1'b0);
        @(negedge clk);
        chk("drain_vB", {31'd0, vB}, 32'd0);

        // Scenario 4: pass-through on A
        drive(2'd0, 8'h55, 1'b1);
        drive(2'd0, 8'h66, 1'b1);
        @(negedge clk);
        chk("pt_vA_full", {31'd0, vA}, 32'd1);
        chk("pt_in_ready", {31'd0, in_ready}, 32'd1);
        drive(2'd0, 8'h00, 1'b0);
        @(negedge clk);
        chk("pt_vA_stays", {31'd0, vA}, 32'd1);
        chk("pt_A", 32'(A), 32'h66);
        chk("pt_cntA", 32'(cntA), 32'd3);

        // Scenario 5: counter saturation on D
        for (int i = 0; i < 5; i++) drive(2'd3, N'(8'hD0 + i), 1'b1);
        drive(2'd0, 8'h00, 1'b0);
        drive(2'd0, 8'h00, 1'b0);
        @(negedge clk);
        chk("sat_cntD", 32'(cntD), C_MAX);
        chk("sat_D_last", 32'(D), 32'hD4);

        // Scenario 6: async reset with A and C full
        r = 4'b1010;
        drive(2'd0, 8'h11, 1'b1);
        drive(2'd2, 8'h22, 1'b1);
        drive(2'd0, 8'h00, 1'b0);
        @(negedge clk);
        chk("ar_vA_pre", {31'd0, vA}, 32'd1);
        chk("ar_vC_pre", {31'd0, vC}, 32'd1);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("ar_vA_async", {31'd0, vA}, 32'd0);
        chk("ar_vC_async", {31'd0, vC}, 32'd0);
        r        = 4'hF;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_state_checks("rst2");
        release_reset("rst2");
        drive(2'd0, 8'h00, 1'b0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_nbit_1x4_demux_stream
`default_nettype wire
